// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: transaction front-end for the spi_v2 master core.
// Buffers outgoing words in a TX FIFO, launches one core transfer per word,
// and captures each received word into an RX FIFO once the transfer ends.
//
// Ports:
//   clk_i, rst_i               core clock, async active-low reset
//   tx_data_i/valid_i/ready_o  system-side TX stream (ready = TX FIFO not full)
//   rx_data_o/valid_o/ready_i  system-side RX stream (FWFT head of RX FIFO)
//   spi_start_o, spi_txdata_o  to core start_i / txdata_i
//   spi_buzy_i, spi_rxdata_i   from core buzy / rxdata_o
//   idle_o                     FSM idle and TX FIFO empty
//   tx_level_o                 TX FIFO occupancy
//   err_o                      sticky transfer-timeout flag
//
// Optional feature macro: SPI_TIMEOUT_EN (busy-handshake watchdog driving err_o).
module spi_xfer_ctrl #(
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned RX_SETTLE      = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_SIZE-1:0]          tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic [DATA_SIZE-1:0]          rx_data_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic                          spi_start_o,
  output logic [DATA_SIZE-1:0]          spi_txdata_o,
  input  logic                          spi_buzy_i,
  input  logic [DATA_SIZE-1:0]          spi_rxdata_i,
  output logic                          idle_o,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level_o,
  output logic                          err_o
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned CNT_MAX = (RX_SETTLE > GAP_CYCLES) ? RX_SETTLE : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  // Elaboration-time guard on the legal parameter space.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      DATA_SIZE < 1 || RX_SETTLE < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("spi_xfer_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_XFER,
    S_SETTLE,
    S_CAPTURE,
    S_GAP
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;

  logic [DATA_SIZE-1:0] r_tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_tx_wr, r_tx_rd;
  logic [CW-1:0]        r_tx_cnt, w_tx_cnt_nxt;
  logic                 r_tx_ready;

  logic [DATA_SIZE-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_rx_wr, r_rx_rd;
  logic [CW-1:0]        r_rx_cnt, w_rx_cnt_nxt;
  logic                 r_rx_valid;

  logic [DATA_SIZE-1:0] r_txdata;
  logic                 r_start;
  logic                 r_idle;

  logic                 w_tx_push, w_tx_pop;
  logic                 w_rx_push, w_rx_pop;

  assign w_tx_push = tx_valid_i & r_tx_ready;
  assign w_rx_pop  = r_rx_valid & rx_ready_i;

`ifdef SPI_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err;
  logic            w_in_wait;
  logic            w_to_hit;

  assign w_in_wait = (r_state == S_WAIT_BUSY) || (r_state == S_XFER);
  assign w_to_hit  = w_in_wait && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles spent waiting on the core's busy handshake.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= w_in_wait ? (r_to_cnt + TO_W'(1)) : '0;
      // Only a timeout can take a busy-wait state straight to GAP.
      if (w_in_wait && (w_state_nxt == S_GAP)) r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  // Occupancy next-state for both FIFOs.
  always_comb begin
    w_tx_cnt_nxt = r_tx_cnt;
    w_rx_cnt_nxt = r_rx_cnt;
    case ({w_tx_push, w_tx_pop})
      2'b10:   w_tx_cnt_nxt = r_tx_cnt + CW'(1);
      2'b01:   w_tx_cnt_nxt = r_tx_cnt - CW'(1);
      default: w_tx_cnt_nxt = r_tx_cnt;
    endcase
    case ({w_rx_push, w_rx_pop})
      2'b10:   w_rx_cnt_nxt = r_rx_cnt + CW'(1);
      2'b01:   w_rx_cnt_nxt = r_rx_cnt - CW'(1);
      default: w_rx_cnt_nxt = r_rx_cnt;
    endcase
  end

  // TX FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_tx_mem   <= '{default: '0};
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_cnt   <= '0;
      r_tx_ready <= 1'b1;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wr] <= tx_data_i;
        r_tx_wr           <= r_tx_wr + AW'(1);
      end
      if (w_tx_pop) r_tx_rd <= r_tx_rd + AW'(1);
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_ready <= (w_tx_cnt_nxt != CW'(FIFO_DEPTH));
    end
  end

  // RX FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_mem   <= '{default: '0};
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_cnt   <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wr] <= spi_rxdata_i;
        r_rx_wr           <= r_rx_wr + AW'(1);
      end
      if (w_rx_pop) r_rx_rd <= r_rx_rd + AW'(1);
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_valid <= (w_rx_cnt_nxt != '0);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // FSM next-state. RX space is checked at launch: RX occupancy can only
  // fall until our own CAPTURE push, so the slot stays reserved implicitly.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tx_pop    = 1'b0;
    w_rx_push   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_tx_cnt != '0) && (r_rx_cnt != CW'(FIFO_DEPTH))) begin
          w_tx_pop    = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (spi_buzy_i) begin
          w_state_nxt = S_XFER;
        end
`ifdef SPI_TIMEOUT_EN
        else if (w_to_hit) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
        end
`endif
      end
      S_XFER: begin
        if (!spi_buzy_i) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = CNT_W'(RX_SETTLE - 1);
        end
`ifdef SPI_TIMEOUT_EN
        else if (w_to_hit) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
        end
`endif
      end
      S_SETTLE: begin
        if (r_cnt == '0) w_state_nxt = S_CAPTURE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      S_CAPTURE: begin
        w_rx_push   = 1'b1;
        w_state_nxt = S_GAP;
        w_cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
      end
      S_GAP: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered core-side and status outputs, decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_start  <= 1'b0;
      r_txdata <= '0;
      r_idle   <= 1'b1;
    end else begin
      r_start <= (w_state_nxt == S_LAUNCH) || (w_state_nxt == S_WAIT_BUSY);
      if (w_tx_pop) r_txdata <= r_tx_mem[r_tx_rd];
      r_idle  <= (w_state_nxt == S_IDLE) && (w_tx_cnt_nxt == '0);
    end
  end

  assign tx_ready_o   = r_tx_ready;
  assign rx_valid_o   = r_rx_valid;
  assign rx_data_o    = r_rx_mem[r_rx_rd];
  assign spi_start_o  = r_start;
  assign spi_txdata_o = r_txdata;
  assign idle_o       = r_idle;
  assign tx_level_o   = r_tx_cnt;

endmodule
